// File: rtl/llsc_monitor_pkg.sv
// Shared types and helpers for the LL/SC reservation monitor.
package llsc_monitor_pkg;

    localparam int LLSC_MAX_THREADS = 8;

    // What a reservation entry does on the next clock edge.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_SET   = 2'd1,
        ACT_CLEAR = 2'd2
    } entry_act_e;

    function automatic int tid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/llsc_entry.sv
// One thread's reservation: valid bit, linked address and optional age counter.
module llsc_entry
    import llsc_monitor_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clear,
    output logic              valid,
    output logic [ADDR_W-1:0] addr
);

    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              expired;
    entry_act_e        act;

    // Flush outranks a same-cycle LL; LL outranks every other kill source.
    always_comb begin
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_CLEAR;
        end else if (set) begin
            act = ACT_SET;
        end else if (clear || expired) begin
            act = ACT_CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
        end else begin
            case (act)
                ACT_SET: begin
                    valid_reg <= 1'b1;
                    addr_reg  <= set_addr;
                end
                ACT_CLEAR: valid_reg <= 1'b0;
                default:   ;
            endcase
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_age
            localparam int              AGE_W    = $clog2(TIMEOUT_CYC + 1);
            localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYC - 1);

            logic [AGE_W-1:0] age_reg;

            assign expired = valid_reg && (age_reg == AGE_LAST);

            // Age never passes AGE_LAST: the entry clears there instead of wrapping.
            always_ff @(posedge clk) begin
                if (rst) begin
                    age_reg <= '0;
                end else if (act == ACT_SET) begin
                    age_reg <= '0;
                end else if (act == ACT_HOLD && valid_reg && age_reg != AGE_LAST) begin
                    age_reg <= age_reg + 1'b1;
                end
            end
        end else begin : g_no_age
            assign expired = 1'b0;
        end
    endgenerate

    assign valid = valid_reg;
    assign addr  = addr_reg;

endmodule

// File: rtl/llsc_monitor.sv
// Per-thread LL/SC reservation tracker with same-cycle SC success answer and store snooping.
module llsc_monitor
    import llsc_monitor_pkg::*;
#(
    parameter int  NUM_THREADS = 2,
    parameter int  ADDR_W      = 32,
    parameter int  GRAN_LSB    = 2,
    parameter int  TIMEOUT_CYC = 0,
    localparam int TID_W       = tid_width(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THREADS-1:0] flush,
    input  logic                   ll_we,
    input  logic [TID_W-1:0]       ll_tid,
    input  logic [ADDR_W-1:0]      ll_addr,
    input  logic                   sc_req,
    input  logic [TID_W-1:0]       sc_tid,
    input  logic [ADDR_W-1:0]      sc_addr,
    output logic                   sc_ok,
    input  logic                   st_we,
    input  logic [TID_W-1:0]       st_tid,
    input  logic                   st_ext,
    input  logic [ADDR_W-1:0]      st_addr,
    output logic [NUM_THREADS-1:0] LLbit_o
);

    localparam logic [ADDR_W-1:0] GRAN_MASK = {ADDR_W{1'b1}} << GRAN_LSB;

    // Granule match done by masking so that every address bit stays in the cone.
    function automatic logic gm(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return ((a ^ b) & GRAN_MASK) == '0;
    endfunction

    logic [NUM_THREADS-1:0] ll_sel;
    logic [NUM_THREADS-1:0] sc_sel;
    logic [NUM_THREADS-1:0] st_sel;
    logic [NUM_THREADS-1:0] sc_hit;
    logic [NUM_THREADS-1:0] clear;
    logic [NUM_THREADS-1:0] valid;
    logic [ADDR_W-1:0]      addr [NUM_THREADS];
    logic                   st_known;
    logic                   sc_race;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
            localparam logic [TID_W-1:0] TID = TID_W'(gi);

            assign ll_sel[gi] = ll_we && (ll_tid == TID);
            assign sc_sel[gi] = sc_req && (sc_tid == TID);
            assign st_sel[gi] = (st_tid == TID);
            assign sc_hit[gi] = sc_sel[gi] && valid[gi] && gm(addr[gi], sc_addr);

            // Own SC, foreign/external store to the granule, or a winning SC from another thread.
            assign clear[gi] = sc_sel[gi]
                || (st_we && st_known && (st_ext || !st_sel[gi]) && gm(st_addr, addr[gi]))
                || (sc_ok && !sc_sel[gi] && gm(sc_addr, addr[gi]));

            llsc_entry #(
                .ADDR_W      (ADDR_W),
                .TIMEOUT_CYC (TIMEOUT_CYC)
            ) u_entry (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush[gi]),
                .set      (ll_sel[gi]),
                .set_addr (ll_addr),
                .clear    (clear[gi]),
                .valid    (valid[gi]),
                .addr     (addr[gi])
            );
        end
    endgenerate

    // A store tagged with a thread id that names no entry is not a real store.
    assign st_known = st_ext || (|st_sel);
    assign sc_race  = st_we && st_known && (st_ext || (st_tid != sc_tid)) && gm(st_addr, sc_addr);
    assign sc_ok    = (|sc_hit) && !sc_race;
    assign LLbit_o  = valid;

endmodule

// File: doc/llsc_monitor.md
Name: llsc_monitor

Overview:
- Multi-thread, address-tracking successor of the single LLbit register. Holds one LL/SC reservation (valid bit, granule address, age counter) per hardware thread.
- Answers SC success queries in the same cycle they are asked.
- Kills reservations on flush, conflicting stores, SC completion and optional timeout.
- Sits beside the MEM/WB stage. It is written from WB-side commit signals and queried from MEM.

Parameters:
- NUM_THREADS, 2, number of hardware threads; one reservation entry per thread (1..8).
- ADDR_W, 32, physical address width.
- GRAN_LSB, 2, reservation granule; addresses compare on [ADDR_W-1:GRAN_LSB] only.
- TIMEOUT_CYC, 0, cycles before an idle reservation self-clears; 0 disables timeout.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset (`RstEnable)
- flush  in  NUM_THREADS  per-thread pipeline flush (exception/eret); clears that thread's entry
- ll_we  in  1  LL commit
- ll_tid  in  TID_W  LL thread id; TID_W = max(1,$clog2(NUM_THREADS))
- ll_addr  in  ADDR_W  LL address
- sc_req  in  1  SC query/commit
- sc_tid  in  TID_W  SC thread id
- sc_addr  in  ADDR_W  SC address
- sc_ok  out  1  combinational; SC may write memory
- st_we  in  1  store observed on the memory bus (any thread or master, SC writes included)
- st_tid  in  TID_W  storing thread
- st_ext  in  1  store comes from an external master; it matches every thread
- st_addr  in  ADDR_W  store address
- LLbit_o  out  NUM_THREADS  per-thread reservation valid, registered

Behaviour:
- Reset: all valid bits, addresses and age counters go to 0; LLbit_o = 0; sc_ok = 0.
- Granule match: gm(a,b) = a[ADDR_W-1:GRAN_LSB] == b[ADDR_W-1:GRAN_LSB].
- sc_ok = sc_req & v[sc_tid] & gm(addr[sc_tid], sc_addr) & ~snoop_kill_same_cycle.
  - snoop_kill_same_cycle = st_we & gm(st_addr, sc_addr) & (st_ext | st_tid != sc_tid).
  - This is conservative: a racing foreign store to the same granule fails the SC.
- Per-entry next state for thread t. Priority is highest first; the first matching row applies.
  1. rst: clear.
  2. flush[t]: clear. Flush beats a simultaneous LL on t.
  3. ll_we & ll_tid==t: set v; addr <= ll_addr; age <= 0. LL beats every clear below in the same cycle.
  4. sc_req & sc_tid==t: clear, whether the SC succeeds or fails.
  5. st_we & gm(st_addr, addr[t]) & (st_ext | st_tid != t): clear. A thread's own plain store does not clear its own link.
  6. sc_ok & sc_tid!=t & gm(sc_addr, addr[t]): clear. A successful SC by another thread kills a matching link.
  7. TIMEOUT_CYC>0 & v & age==TIMEOUT_CYC-1: clear.
  8. Otherwise, if v: age <= age+1. Age saturates and never wraps; it is width $clog2(TIMEOUT_CYC+1). When TIMEOUT_CYC==0 the counter is removed.
- LLbit_o[t] = v[t] and is visible the cycle after the write.
- Latency:
  - sc_ok: 0 cycles.
  - Set or clear reaching LLbit_o: 1 cycle.
- Re-issuing LL on a valid entry overwrites addr and restarts age.
- Out-of-range tid (≥NUM_THREADS): ignored, with no state change; sc_ok = 0.
- Reset asserted mid-sequence overrides everything, including a same-cycle LL or SC.

Decomposition:
- defines.v, the shared header, holds `RstEnable, `WriteEnable and new `LLSC_MAX_THREADS.
- Natural sub-module llsc_entry: one thread's valid, addr, age and its clear/set priority logic.
  - Inputs: pre-decoded set, clear and age-enable strobes.
- llsc_monitor:
  - Generates NUM_THREADS llsc_entry instances.
  - Decodes the tid ports and builds the snoop and SC-kill match vectors.
  - Forms sc_ok.

Test Plan:
- Basic pass:
  - Stimulus: rst 2 cycles; LL t0 @0x100; next cycle SC t0 @0x100.
  - Required: sc_ok=1; LLbit_o[0] 1→0 after the SC.
- Granule:
  - Stimulus: LL t0 @0x100; SC t0 @0x103; then LL t0 @0x100 and SC t0 @0x104.
  - Required: sc_ok=1 for 0x103, sc_ok=0 for 0x104; entry cleared both times.
- Cross-thread kill:
  - Stimulus: LL t0 @0x200, LL t1 @0x200; SC t1 @0x200 succeeds; SC t0 @0x200.
  - Required: t1 sc_ok=1, LLbit_o=2'b00 next cycle; t0 sc_ok=0.
- Snoop vs own store:
  - Stimulus: LL t0 @0x300; st_we t0 @0x300; then st_we st_ext=1 @0x300.
  - Required: LLbit_o[0] stays 1 after the own store and clears after the external store.
- Simultaneous events:
  - Stimulus 1: same cycle, flush[0] + LL t0 @0x40. Required: entry 0 cleared.
  - Stimulus 2: LL t1 @0x40 + foreign store @0x40 in the same cycle. Required: LLbit_o[1]=1.
  - Stimulus 3: SC t1 @0x40 with a same-cycle external store @0x40. Required: sc_ok=0.
- Timeout (TIMEOUT_CYC=4):
  - Stimulus: LL t0 @0x80, then idle.
  - Required: LLbit_o[0]=1 for exactly 4 cycles, then 0. A re-LL at cycle 3 extends it to 4 more cycles.
  - With TIMEOUT_CYC=0: link persists after 1000 idle cycles.
